// File: rtl/pulse_sched_pkg.sv
// pulse_sched shared definitions.
// State encoding, default counter width and requester indices.
package pulse_sched_pkg;

   localparam int CNT_W_DEF = 4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HIGH = 2'd1;
   localparam logic [1:0] S_LOW  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   function automatic logic [1:0] onehot(input logic idx);
      return (idx == REQ1) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/pulse_sched_if.sv
// pulse_sched requester/generator bundle.
// master = test-sequencing side, slave = scheduler.
interface pulse_sched_if #(
   parameter int CNT_W = 4
);

   logic [1:0]       req;
   logic [CNT_W-1:0] n_cfg0;
   logic [CNT_W-1:0] m_cfg0;
   logic [CNT_W-1:0] n_cfg1;
   logic [CNT_W-1:0] m_cfg1;
   logic             abort;
   logic             OUT;
   logic             busy;
   logic [1:0]       grant;
   logic [1:0]       done;
   logic             err;

   modport master (
      output req, n_cfg0, m_cfg0, n_cfg1, m_cfg1, abort,
      input  OUT, busy, grant, done, err
   );

   modport slave (
      input  req, n_cfg0, m_cfg0, n_cfg1, m_cfg1, abort,
      output OUT, busy, grant, done, err
   );

endinterface

// File: rtl/pulse_sched_phase_cnt.sv
// Loadable down-counter that stops at 1.
// Used for both the phase length and the repeat count.
module pulse_sched_phase_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         last
);

   logic [W-1:0] cnt;

   // load has priority; decrement saturates at 1 so the count never wraps
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt > W'(1))) begin
         cnt <= cnt - W'(1);
      end
   end

   assign last = (cnt == W'(1));

endmodule

// File: rtl/pulse_sched.sv
// Two-requester round-robin scheduler for the pulse-train generator.
// OUT is high N cycles, low N cycles, repeated M times per grant.
module pulse_sched
   import pulse_sched_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input logic          clk,
   input logic          reset,
   pulse_sched_if.slave bus
);

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic [1:0]       grant_q;
   logic             last_q;
   logic             err_q;
   logic             err_d;
   logic [CNT_W-1:0] n_q;

   logic             st_idle;
   logic             st_high;
   logic             st_low;
   logic             st_done;
   logic             active;

   logic             any_req;
   logic             win;
   logic             start;
   logic             zero_cfg;
   logic [CNT_W-1:0] win_n;
   logic [CNT_W-1:0] win_m;

   logic             ph_load;
   logic             ph_dec;
   logic             ph_last;
   logic [CNT_W-1:0] ph_val;
   logic             rep_dec;
   logic             rep_last;

   assign st_idle = (state_q == S_IDLE);
   assign st_high = (state_q == S_HIGH);
   assign st_low  = (state_q == S_LOW);
   assign st_done = (state_q == S_DONE);
   assign active  = st_high | st_low;

   // when both ask, the one not granted last wins
   assign any_req  = |bus.req;
   assign win      = (&bus.req) ? ~last_q : bus.req[1];
   assign win_n    = (win == REQ1) ? bus.n_cfg1 : bus.n_cfg0;
   assign win_m    = (win == REQ1) ? bus.m_cfg1 : bus.m_cfg0;
   assign zero_cfg = (win_n == '0) | (win_m == '0);
   assign start    = st_idle & any_req;

   // phase counter reloads at grant and at every HIGH/LOW boundary
   assign ph_load = start | (active & ph_last);
   assign ph_val  = st_idle ? win_n : n_q;
   assign ph_dec  = active & ~ph_last;
   assign rep_dec = st_low & ph_last & ~rep_last;

   assign err_d = (start & zero_cfg) | (active & bus.abort);

   pulse_sched_phase_cnt #(
      .W(CNT_W)
   ) u_phase (
      .clk      (clk),
      .reset    (reset),
      .load     (ph_load),
      .load_val (ph_val),
      .dec      (ph_dec),
      .last     (ph_last)
   );

   pulse_sched_phase_cnt #(
      .W(CNT_W)
   ) u_repeat (
      .clk      (clk),
      .reset    (reset),
      .load     (start),
      .load_val (win_m),
      .dec      (rep_dec),
      .last     (rep_last)
   );

   // next-state decode
   always_comb begin
      state_d = state_q;
      unique case (1'b1)
         st_idle: begin
            if (start) begin
               state_d = zero_cfg ? S_DONE : S_HIGH;
            end
         end
         st_high: begin
            if (bus.abort) begin
               state_d = S_DONE;
            end else if (ph_last) begin
               state_d = S_LOW;
            end
         end
         st_low: begin
            if (bus.abort) begin
               state_d = S_DONE;
            end else if (ph_last) begin
               state_d = rep_last ? S_DONE : S_HIGH;
            end
         end
         st_done: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // grant, pointer and latched N captured only at grant
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_q <= 2'b00;
         last_q  <= REQ1;
         n_q     <= '0;
      end else if (start) begin
         grant_q <= onehot(win);
         last_q  <= win;
         n_q     <= win_n;
      end else if (st_done) begin
         grant_q <= 2'b00;
      end
   end

   // error flag is set on the edge into DONE and lasts one cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign bus.OUT   = st_high;
   assign bus.busy  = active;
   assign bus.grant = grant_q;
   assign bus.done  = st_done ? grant_q : 2'b00;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_pulse_sched.sv
// pulse_sched bench: table vectors, corner sequences, random trains.
// Expected waveforms come from the N/M pulse-train formula.
module tb_pulse_sched;

   localparam int W = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   pulse_sched_if #(.CNT_W(W)) bus ();

   pulse_sched #(
      .CNT_W(W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_pass = 0;
   int n_tot  = 0;
   bit mdl_last;

   logic [6:0] obs;
   assign obs = {bus.OUT, bus.busy, bus.grant, bus.done, bus.err};

   typedef struct {
      int r;
      int n;
      int m;
      int ab;
      int len;
      bit err;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string nm, input logic [6:0] got,
                      input logic [6:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %b want %b (OUT busy grant done err)",
                    nm, got, exp);
   endtask

   task automatic set_cfg(input int r, input int n, input int m);
      if (r == 0) begin
         bus.n_cfg0 = W'(n);
         bus.m_cfg0 = W'(m);
      end else begin
         bus.n_cfg1 = W'(n);
         bus.m_cfg1 = W'(m);
      end
   endtask

   // req[r] and cfg already set; next posedge is the grant edge
   task automatic run_train(input int r, input int n, input int m,
                            input int ab, input int len, input bit e_err);
      logic [1:0] oh;
      logic [6:0] exp;
      oh = (r == 1) ? 2'b10 : 2'b01;
      for (int k = 0; k <= len; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k < len)
            exp = {(((k / n) % 2) == 0), 1'b1, oh, 2'b00, 1'b0};
         else
            exp = {1'b0, 1'b0, oh, oh, e_err};
         chk($sformatf("train r%0d n%0d m%0d k%0d", r, n, m, k), obs, exp);
         bus.abort = (k == ab);
         if (k == 0) set_cfg(r, $urandom, $urandom);
         if (k == len) bus.req[r] = 1'b0;
      end
      bus.abort = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("idle after r%0d", r), obs, 7'b0);
      mdl_last = r[0];
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int pend;
      int w;
      int len;
      bit e_err;
      int nr[2];
      int mr[2];
      int ab[2];

      tbl[0] = '{0, 2, 3, -1, 12, 1'b0};
      tbl[1] = '{1, 0, 4, -1, 0, 1'b1};
      tbl[2] = '{0, 3, 5, 9, 10, 1'b1};
      tbl[3] = '{1, 1, 1, -1, 2, 1'b0};
      tbl[4] = '{0, 15, 15, -1, 450, 1'b0};
      tbl[5] = '{1, 7, 0, -1, 0, 1'b1};

      reset = 1'b1;
      bus.req = 2'b00;
      bus.abort = 1'b0;
      set_cfg(0, 0, 0);
      set_cfg(1, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset state", obs, 7'b0);
      reset = 1'b0;
      mdl_last = 1'b1;

      // both at once after reset: 0 first, then 1, then 0 again
      set_cfg(0, 1, 1);
      set_cfg(1, 1, 1);
      bus.req = 2'b11;
      run_train(0, 1, 1, -1, 2, 1'b0);
      run_train(1, 1, 1, -1, 2, 1'b0);
      set_cfg(0, 1, 1);
      set_cfg(1, 2, 1);
      bus.req = 2'b11;
      run_train(0, 1, 1, -1, 2, 1'b0);
      run_train(1, 2, 1, -1, 4, 1'b0);

      for (int i = 0; i < 6; i++) begin
         set_cfg(tbl[i].r, tbl[i].n, tbl[i].m);
         bus.req[tbl[i].r] = 1'b1;
         run_train(tbl[i].r, tbl[i].n, tbl[i].m, tbl[i].ab,
                   tbl[i].len, tbl[i].err);
      end

      // reset in the middle of HIGH, then a clean restart
      set_cfg(0, 4, 2);
      bus.req[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("pre-reset k0", obs, 7'b1101000);
      @(posedge clk);
      @(negedge clk);
      chk("pre-reset k1", obs, 7'b1101000);
      set_cfg(0, 4, 2);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mid-train reset", obs, 7'b0);
      reset = 1'b0;
      mdl_last = 1'b1;
      run_train(0, 4, 2, -1, 16, 1'b0);

      for (int it = 0; it < 30; it++) begin
         pend = $urandom_range(1, 3);
         for (int r = 0; r < 2; r++) begin
            nr[r] = $urandom_range(0, 6);
            mr[r] = $urandom_range(0, 6);
            ab[r] = -1;
            if (nr[r] * mr[r] > 0 && $urandom_range(0, 3) == 0)
               ab[r] = $urandom_range(0, 2 * nr[r] * mr[r] - 1);
            set_cfg(r, nr[r], mr[r]);
         end
         bus.req = pend[1:0];
         while (pend != 0) begin
            if (pend == 3) w = mdl_last ? 0 : 1;
            else w = (pend == 2) ? 1 : 0;
            if (nr[w] == 0 || mr[w] == 0) begin
               len = 0;
               e_err = 1'b1;
            end else if (ab[w] >= 0) begin
               len = ab[w] + 1;
               e_err = 1'b1;
            end else begin
               len = 2 * nr[w] * mr[w];
               e_err = 1'b0;
            end
            run_train(w, nr[w], mr[w], ab[w], len, e_err);
            pend = pend & ~(1 << w);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
